seq_calc: RTL and testbench

//  Parametrised, clocked successor to the 4-bit combinational calculator. It takes two signed WIDTH-bit

---
 rtl/seq_calc_pkg.sv | 22 ++
 rtl/seq_calc_mul.sv | 55 +++++
 rtl/seq_calc.sv | 161 ++++++++++++++++
 tb/tb_seq_calc.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_calc_pkg.sv
// Shared opcode and FSM state types for the sequential calculator.
package seq_calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NEG  = 3'b010,
    OP_MUL  = 3'b011,
    OP_ABS  = 3'b100,
    OP_MIN  = 3'b101,
    OP_MAX  = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MULT = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_calc_mul.sv
// Iterative WIDTH-cycle signed multiplier: shift-add on operand magnitudes, sign applied at the end.
module seq_calc_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 fin
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic [CW-1:0]      cnt;

  // The magnitude of -2^(WIDTH-1) still fits when read as unsigned.
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  // prod includes the step in progress, so it is final while fin is high.
  assign sum  = acc + (mplier[0] ? mcand : '0);
  assign prod = neg ? -sum : sum;
  assign fin  = (cnt == CW'(1));

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      acc    <= '0;
      mplier <= mag_b;
      neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/seq_calc.sv
// Clocked signed calculator with start/busy/done handshake and an iterative multiply.
// Define SEQ_CALC_ACC_EN to add an accumulator that can replace operand A (use_acc).
//
// state | meaning
// IDLE  | waiting for start
// EXEC  | single-cycle ALU op in progress
// MULT  | shift-add multiply, WIDTH cycles
// DONE  | result/ovf valid this cycle; new start accepted
module seq_calc
  import seq_calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int               M        = WIDTH - 1;

  state_t             state, state_nx;
  op_t                rop;
  logic [WIDTH-1:0]   ra, rb;
  logic [WIDTH-1:0]   a_src;
  logic               accept, mul_load, mul_fin, load_res;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     mul_hi;
  logic [WIDTH-1:0]   alu_sum, alu_dif, alu_neg, alu_res, res_nx;
  logic               alu_ovf, ovf_nx;

`ifdef SEQ_CALC_ACC_EN
  logic [WIDTH-1:0] acc;

  assign a_src = use_acc ? acc : a;

  always_ff @(posedge CLOCK_50) begin
    if (Reset)         acc <= '0;
    else if (load_res) acc <= res_nx;
  end
`else
  logic unused_use_acc;

  assign unused_use_acc = use_acc;
  assign a_src          = a;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    mul_load = 1'b0;
    load_res = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          accept   = 1'b1;
          mul_load = (op_t'(op) == OP_MUL);
          state_nx = mul_load ? MULT : EXEC;
        end else begin
          state_nx = IDLE;
        end
      end
      EXEC: begin
        busy     = 1'b1;
        load_res = 1'b1;
        state_nx = DONE;
      end
      MULT: begin
        busy = 1'b1;
        if (mul_fin) begin
          load_res = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  seq_calc_mul #(.WIDTH(WIDTH)) u_mul (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .load     (mul_load),
    .a        (a_src),
    .b        (b),
    .prod     (mul_prod),
    .fin      (mul_fin)
  );

  assign alu_sum = ra + rb;
  assign alu_dif = ra - rb;
  assign alu_neg = -ra;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (rop)
      OP_ADD: begin
        alu_res = alu_sum;
        alu_ovf = (ra[M] == rb[M]) && (alu_sum[M] != ra[M]);
      end
      OP_SUB: begin
        alu_res = alu_dif;
        alu_ovf = (ra[M] != rb[M]) && (alu_dif[M] != ra[M]);
      end
      OP_NEG: begin
        alu_res = alu_neg;
        alu_ovf = (ra == MOST_NEG);
      end
      OP_ABS: begin
        alu_res = ra[M] ? alu_neg : ra;
        alu_ovf = (ra == MOST_NEG);
      end
      OP_MIN:  alu_res = ($signed(ra) < $signed(rb)) ? ra : rb;
      OP_MAX:  alu_res = ($signed(ra) > $signed(rb)) ? ra : rb;
      OP_PASS: alu_res = ra;
      default: alu_res = '0;
    endcase
  end

  // Product fits in WIDTH signed bits only if its top WIDTH+1 bits are all equal.
  assign mul_hi = mul_prod[2*WIDTH-1:WIDTH-1];
  assign res_nx = (state == MULT) ? mul_prod[WIDTH-1:0] : alu_res;
  assign ovf_nx = (state == MULT) ? !((&mul_hi) || (~|mul_hi)) : alu_ovf;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      ra     <= '0;
      rb     <= '0;
      rop    <= OP_ADD;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        ra  <= a_src;
        rb  <= b;
        rop <= op_t'(op);
      end
      if (load_res) begin
        result <= res_nx;
        ovf    <= ovf_nx;
      end
    end
  end

endmodule

// File: tb/tb_seq_calc.sv
// Self-checking bench for seq_calc: WIDTH=4 instance for most scenarios, WIDTH=8 for wide multiply.
module tb_seq_calc;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0, use_acc = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, ovf;
  logic [W-1:0] result;

  logic          start8 = 1'b0;
  logic [2:0]    op8 = 3'd0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          busy8, done8, ovf8;
  logic [W8-1:0] result8;

  int checks = 0;
  int failures = 0;

  seq_calc #(.WIDTH(W)) dut (
    .CLOCK_50(clk), .Reset(rst), .start(start), .op(op), .a(a), .b(b),
    .use_acc(use_acc), .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  seq_calc #(.WIDTH(W8)) dut8 (
    .CLOCK_50(clk), .Reset(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .use_acc(1'b0), .busy(busy8), .done(done8), .result(result8), .ovf(ovf8)
  );

  // Reference: exact integer arithmetic, then wrap to W bits; ovf when the exact value is out of range.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                output logic [W-1:0] r, output logic ov);
    longint sa, sb, full, lo, hi;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    lo = -(longint'(1) <<< (W-1));
    hi = (longint'(1) <<< (W-1)) - 1;
    case (o)
      3'd0: full = sa + sb;
      3'd1: full = sa - sb;
      3'd2: full = -sa;
      3'd3: full = sa * sb;
      3'd4: full = (sa < 0) ? -sa : sa;
      3'd5: full = (sa < sb) ? sa : sb;
      3'd6: full = (sa > sb) ? sa : sb;
      default: full = sa;
    endcase
    r  = full[W-1:0];
    ov = (full < lo) || (full > hi);
  endfunction

  // Issue one op; returns result, ovf, done latency in cycles after the start cycle (-1 on timeout),
  // and the number of pre-done cycles where busy was low.
  task automatic go(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ua,
                    output logic [W-1:0] r, output logic ov, output int lat, output int bb_bad);
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb; use_acc = ua;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bb_bad = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
      else if (!busy) bb_bad++;
    end
    if (!seen) lat = -1;
    r = result; ov = ovf;
  endtask

  task automatic go8(input logic [2:0] o, input logic [W8-1:0] aa, input logic [W8-1:0] bb,
                     output logic [W8-1:0] r, output logic ov, output int lat);
    bit seen = 0;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = aa; b8 = bb;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done8) seen = 1;
    end
    if (!seen) lat = -1;
    r = result8; ov = ovf8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, result, ovf} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset4: busy=%b done=%b result=%h ovf=%b, want all 0", busy, done, result, ovf);
    end
    checks++;
    if ({busy8, done8, result8, ovf8} !== {1'b0, 1'b0, {W8{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset8: busy=%b done=%b result=%h ovf=%b, want all 0", busy8, done8, result8, ovf8);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] a, b, r;
    logic         ov;
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[9];
    logic [W-1:0] r;
    logic ov;
    int lat, bb_bad;
    v[0] = '{3'd0, 4'd7,  4'd1,  4'b1000, 1'b1, 2};
    v[1] = '{3'd1, 4'b1000, 4'd1, 4'b0111, 1'b1, 2};
    v[2] = '{3'd3, 4'd3,  4'b1110, 4'b1010, 1'b0, 5};
    v[3] = '{3'd3, 4'b1000, 4'b1111, 4'b1000, 1'b1, 5};
    v[4] = '{3'd2, 4'b1000, 4'd0, 4'b1000, 1'b1, 2};
    v[5] = '{3'd4, 4'b1011, 4'd0, 4'b0101, 1'b0, 2};
    v[6] = '{3'd5, 4'b1101, 4'd2, 4'b1101, 1'b0, 2};
    v[7] = '{3'd6, 4'b1101, 4'd2, 4'b0010, 1'b0, 2};
    v[8] = '{3'd7, 4'd6,  4'd9,  4'b0110, 1'b0, 2};
    for (int i = 0; i < 9; i++) begin
      go(v[i].o, v[i].a, v[i].b, 1'b0, r, ov, lat, bb_bad);
      checks++;
      if ({r, ov} !== {v[i].r, v[i].ov} || lat != v[i].lat || bb_bad != 0) begin
        failures++;
        $display("FAIL directed[%0d] op=%0d: result=%h ovf=%b lat=%0d busy_low=%0d, want result=%h ovf=%b lat=%0d busy_low=0",
                 i, v[i].o, r, ov, lat, bb_bad, v[i].r, v[i].ov, v[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r, er, ra, rb;
    logic ov, eov;
    logic [2:0] o;
    int lat, bb_bad, elat;
    for (int i = 0; i < 150; i++) begin
      o  = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      model(o, ra, rb, er, eov);
      elat = (o == 3'd3) ? W + 1 : 2;
      go(o, ra, rb, 1'b0, r, ov, lat, bb_bad);
      checks++;
      if ({r, ov} !== {er, eov} || lat != elat || bb_bad != 0) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h ovf=%b lat=%0d busy_low=%0d, want result=%h ovf=%b lat=%0d",
                 i, o, ra, rb, r, ov, lat, bb_bad, er, eov, elat);
      end
    end
  endtask

  task automatic test_acc();
    logic [W-1:0] r, want;
    logic ov;
    int lat, bb_bad;
    go(3'd0, 4'd2, 4'd3, 1'b0, r, ov, lat, bb_bad);
    checks++;
    if (r !== 4'd5) begin
      failures++;
      $display("FAIL acc_first: result=%h, want 5", r);
    end
`ifdef SEQ_CALC_ACC_EN
    want = 4'd6;
`else
    want = 4'd1;
`endif
    go(3'd0, 4'd0, 4'd1, 1'b1, r, ov, lat, bb_bad);
    checks++;
    if ({r, ov} !== {want, 1'b0}) begin
      failures++;
      $display("FAIL acc_second: result=%h ovf=%b, want result=%h ovf=0", r, ov, want);
    end
    use_acc = 1'b0;
  endtask

  task automatic test_drop_while_busy();
    int ndone = 0, first = -1;
    logic [W-1:0] r = '0;
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 4'd3; b = 4'b1110;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        r = result;
        if (first < 0) first = i + 1;
      end
      if (i == 1) begin start = 1'b1; op = 3'd0; a = 4'd7; b = 4'd1; end
      if (i == 3) start = 1'b0;
    end
    checks++;
    if (ndone != 1 || r !== 4'b1010 || first != 5) begin
      failures++;
      $display("FAIL drop_while_busy: dones=%0d result=%h lat=%0d, want dones=1 result=a lat=5", ndone, r, first);
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 4'd2; b = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen || result !== 4'd5) begin
      failures++;
      $display("FAIL b2b_first: seen=%0d result=%h, want seen=1 result=5", seen, result);
    end
    start = 1'b1; op = 3'd1; a = 4'd1; b = 4'd4;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen || lat != 2 || {result, ovf} !== {4'b1101, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second: seen=%0d lat=%0d result=%h ovf=%b, want lat=2 result=d ovf=0",
               seen, lat, result, ovf);
    end
  endtask

  task automatic test_reset_mid_mult();
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 4'd7; b = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, result, ovf} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_mult: busy=%b done=%b result=%h ovf=%b, want all 0", busy, done, result, ovf);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL reset_no_done: dones=%0d, want 0", ndone);
    end
  endtask

  task automatic test_width8();
    logic [W8-1:0] r;
    logic ov;
    int lat;
    go8(3'd3, 8'd12, 8'd10, r, ov, lat);
    checks++;
    if ({r, ov} !== {8'd120, 1'b0} || lat != 9) begin
      failures++;
      $display("FAIL mul8_12x10: result=%h ovf=%b lat=%0d, want result=78 ovf=0 lat=9", r, ov, lat);
    end
    go8(3'd3, 8'd16, 8'd8, r, ov, lat);
    checks++;
    if ({r, ov} !== {8'h80, 1'b1} || lat != 9) begin
      failures++;
      $display("FAIL mul8_16x8: result=%h ovf=%b lat=%0d, want result=80 ovf=1 lat=9", r, ov, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_acc();
    test_drop_while_busy();
    test_back_to_back();
    test_reset_mid_mult();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
